// File: rtl/uncache_req.sv
// Uncached (MMIO) request initiator: one outstanding single-beat bus access per MEM-stage request.
// Optional WAIT-state timeout is enabled by defining UNCACHE_TIMEOUT_EN.
module uncache_req #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                stall,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                mem_req_valid_q;
  logic                mem_resp_ready_q;
  logic                resp_valid_q;

`ifdef UNCACHE_TIMEOUT_EN
  localparam int unsigned CntW =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic            timeout;

  // Counter holds the number of WAIT cycles already completed.
  assign timeout  = (cnt_q == CntW'(TIMEOUT_CYC - 1));
  assign resp_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign resp_err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      we_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      rdata_q          <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_resp_ready_q <= 1'b0;
      resp_valid_q     <= 1'b0;
`ifdef UNCACHE_TIMEOUT_EN
      cnt_q            <= '0;
      err_q            <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q            <= req_we;
            addr_q          <= req_addr;
            wdata_q         <= req_wdata;
            wstrb_q         <= req_we ? req_wstrb : '0;
            mem_req_valid_q <= 1'b1;
            state_q         <= StReq;
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b1;
`ifdef UNCACHE_TIMEOUT_EN
            cnt_q            <= '0;
`endif
            state_q          <= StWait;
          end
        end
        StWait: begin
          // A response in the timeout cycle still wins over the timeout.
          if (mem_resp_valid) begin
            rdata_q          <= we_q ? '0 : mem_resp_rdata;
            mem_resp_ready_q <= 1'b0;
            resp_valid_q     <= 1'b1;
`ifdef UNCACHE_TIMEOUT_EN
            err_q            <= 1'b0;
`endif
            state_q          <= StResp;
          end
`ifdef UNCACHE_TIMEOUT_EN
          else if (timeout) begin
            rdata_q          <= '0;
            mem_resp_ready_q <= 1'b0;
            resp_valid_q     <= 1'b1;
            err_q            <= 1'b1;
            state_q          <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          resp_valid_q <= 1'b0;
`ifdef UNCACHE_TIMEOUT_EN
          err_q        <= 1'b0;
`endif
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall is combinational in IDLE so the pipeline freezes in the acceptance cycle.
  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      StIdle:         stall = req_valid;
      StReq, StWait:  stall = 1'b1;
      default:        stall = 1'b0;
    endcase
  end

  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = rdata_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_we     = we_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wstrb  = wstrb_q;
  assign mem_resp_ready = mem_resp_ready_q;

endmodule

// File: tb/tb_uncache_req.sv
// Self-checking bench for uncache_req: directed and randomized accesses with a bus model.
module tb_uncache_req;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        stall;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [63:0] mem_resp_rdata;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_addr_q[$];
  logic [63:0] mon_addr_q[$];

  uncache_req #(
    .ADDR_W     (64),
    .DATA_W     (64),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  // Bus-side record of every accepted request.
  always @(posedge clk) begin
    if (rst && mem_req_valid && mem_req_ready) mon_addr_q.push_back(mem_req_addr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic junk_req();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_wstrb = 8'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_mem_req_we"}, 64'(mem_req_we), 64'd0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 64'd0);
    chk({tag, "_mem_req_wdata"}, mem_req_wdata, 64'd0);
    chk({tag, "_mem_req_wstrb"}, 64'(mem_req_wstrb), 64'd0);
    chk({tag, "_mem_resp_ready"}, 64'(mem_resp_ready), 64'd0);
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge of the IDLE cycle after RESP.
  task automatic run_txn(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] strb, input int rdy_dly, input int resp_dly,
                         input logic [63:0] rdata, input bit chain, input bit spur);
    logic [63:0] exp_rdata;
    logic [7:0]  exp_strb;
    exp_rdata = we ? 64'd0 : rdata;
    exp_strb  = we ? strb : 8'd0;
    exp_addr_q.push_back(addr);

    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    #1;
    chk("idle_stall", 64'(stall), 64'd1);
    chk("idle_no_req", 64'(mem_req_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i <= rdy_dly; i++) begin
      junk_req();
      mem_req_ready  = (i == rdy_dly);
      mem_resp_valid = spur && (i == 0);
      mem_resp_rdata = 64'hdead;
      #1;
      chk("req_valid", 64'(mem_req_valid), 64'd1);
      chk("req_we", 64'(mem_req_we), 64'(we));
      chk("req_addr", mem_req_addr, addr);
      chk("req_wdata", mem_req_wdata, wdata);
      chk("req_wstrb", 64'(mem_req_wstrb), 64'(exp_strb));
      chk("req_stall", 64'(stall), 64'd1);
      chk("req_resp_ready", 64'(mem_resp_ready), 64'd0);
      chk("req_resp_valid", 64'(resp_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;

    for (int j = 0; j <= resp_dly; j++) begin
      junk_req();
      mem_resp_valid = (j == resp_dly);
      mem_resp_rdata = (j == resp_dly) ? rdata : {$urandom, $urandom};
      #1;
      chk("wait_resp_ready", 64'(mem_resp_ready), 64'd1);
      chk("wait_stall", 64'(stall), 64'd1);
      chk("wait_req_valid", 64'(mem_req_valid), 64'd0);
      chk("wait_resp_valid", 64'(resp_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end

    junk_req();
    if (chain) req_valid = 1'b1;
    mem_resp_valid = 1'($urandom);
    mem_resp_rdata = {$urandom, $urandom};
    #1;
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("resp_stall", 64'(stall), 64'd0);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_err", 64'(resp_err), 64'd0);
    chk("resp_req_valid", 64'(mem_req_valid), 64'd0);
    chk("resp_resp_ready", 64'(mem_resp_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);

    req_valid      = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    chk("post_resp_valid", 64'(resp_valid), 64'd0);
    chk("post_req_valid", 64'(mem_req_valid), 64'd0);
    chk("post_stall", 64'(stall), 64'd0);
    chk("post_rdata_hold", resp_rdata, exp_rdata);
  endtask

  initial begin
    rst            = 1'b0;
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    req_wstrb      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Load with immediate ready, response after two WAIT cycles.
    run_txn(1'b0, 64'ha000_0048, 64'd0, 8'h00, 0, 2, 64'h1122334455667788, 1'b0, 1'b0);
    // Store with ready held low for four cycles.
    run_txn(1'b1, 64'ha000_0100, 64'hff, 8'h01, 4, 1, 64'h5555_aaaa_5555_aaaa, 1'b0, 1'b0);
    // Back-to-back: req_valid held high through RESP.
    run_txn(1'b0, 64'ha000_0200, 64'd0, 8'hff, 1, 0, 64'h0123_4567_89ab_cdef, 1'b1, 1'b0);
    run_txn(1'b1, 64'ha000_0208, 64'hcafe, 8'hf0, 0, 3, 64'h1, 1'b0, 1'b0);
    // Spurious response during REQ is ignored.
    run_txn(1'b0, 64'ha000_0300, 64'd0, 8'h00, 2, 1, 64'h0bad_f00d_1234_5678, 1'b0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      run_txn(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), {$urandom, $urandom},
              1'($urandom), 1'($urandom));
    end

    // Reset while in WAIT abandons the access silently.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 64'ha000_0400;
    req_wdata = 64'h77;
    req_wstrb = 8'h0f;
    exp_addr_q.push_back(64'ha000_0400);
    @(posedge clk);
    @(negedge clk);
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("rstw_in_wait", 64'(mem_resp_ready), 64'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("rstw");
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hdead;
    repeat (2) @(negedge clk);
    rst            = 1'b1;
    mem_resp_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("rstw_no_resp", 64'(resp_valid), 64'd0);
      chk("rstw_rdata", resp_rdata, 64'd0);
      @(negedge clk);
    end
    run_txn(1'b0, 64'ha000_0408, 64'd0, 8'h00, 1, 1, 64'h8765_4321_0fed_cba9, 1'b0, 1'b0);

`ifdef UNCACHE_TIMEOUT_EN
    // Response in the 16th WAIT cycle beats the timeout.
    run_txn(1'b0, 64'ha000_0500, 64'd0, 8'h00, 0, 15, 64'h2468_ace0_1357_9bdf, 1'b0, 1'b0);
    // No response: timeout after 16 WAIT cycles.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 64'ha000_0508;
    exp_addr_q.push_back(64'ha000_0508);
    @(posedge clk);
    @(negedge clk);
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("to_wait_ready", 64'(mem_resp_ready), 64'd1);
      chk("to_wait_resp", 64'(resp_valid), 64'd0);
      @(negedge clk);
    end
    #1;
    chk("to_resp_valid", 64'(resp_valid), 64'd1);
    chk("to_resp_err", 64'(resp_err), 64'd1);
    chk("to_resp_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    #1;
    chk("to_post_valid", 64'(resp_valid), 64'd0);
`endif

    chk("bus_req_count", 64'(mon_addr_q.size()), 64'(exp_addr_q.size()));
    for (int k = 0; k < exp_addr_q.size() && k < mon_addr_q.size(); k++) begin
      chk("bus_req_addr", mon_addr_q[k], exp_addr_q[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
